regfile_scoreboard: RTL and testbench

- Architectural register file plus per-register pending scoreboard; the responder side of the decode stage's rs1/rs2 read interface.
- Decode presents rs1/rs2 addresses, gets operand data and busy flags back, and posts the destination register of each issued instruction.
- Writeback updates data and clears the pending flag.
- Produces the decode stall signal for RAW and WAW hazards.

---
 rtl/regfile_scoreboard.sv | 99 +++++++++
 tb/tb_regfile_scoreboard.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Architectural register file with a per-register pending scoreboard.
// Serves decode's rs1/rs2 reads, raises the RAW/WAW stall and tracks outstanding writes.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_uses_rs1,
    input  logic            issue_uses_rs2,
    output logic            stall,
    output logic            issue_accept,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [AW:0]     num_pending
);

    // Entry 0 is never written and resets to zero, so x0 folds to constants.
    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic wb_write;
    logic issue_mark;
    logic rd_busy;
    logic pend_inc;
    logic pend_dec;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (rs1_addr != '0) begin
            if (wb_valid && wb_rd == rs1_addr) begin
                rs1_data = wb_data;
            end else begin
                rs1_data = regs[rs1_addr];
                rs1_busy = busy[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (rs2_addr != '0) begin
            if (wb_valid && wb_rd == rs2_addr) begin
                rs2_data = wb_data;
            end else begin
                rs2_data = regs[rs2_addr];
                rs2_busy = busy[rs2_addr];
            end
        end
    end

    always_comb begin
        rd_busy      = (issue_rd != '0) && busy[issue_rd] && !(wb_valid && wb_rd == issue_rd);
        stall        = issue_valid && ((issue_uses_rs1 && rs1_busy) ||
                                       (issue_uses_rs2 && rs2_busy) || rd_busy);
        issue_accept = issue_valid && !stall;

        wb_write   = wb_valid && (wb_rd != '0);
        issue_mark = issue_accept && (issue_rd != '0);
        // A same-register issue keeps the bit set, so the writeback does not decrement.
        pend_inc   = issue_mark && !busy[issue_rd];
        pend_dec   = wb_write && busy[wb_rd] && !(issue_mark && issue_rd == wb_rd);
    end

    // NOTE: the register array is cleared on reset because software-visible state must start at zero.
    // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy        <= '0;
            num_pending <= '0;
        end else begin
            if (wb_write) begin
                regs[wb_rd] <= wb_data;
                busy[wb_rd] <= 1'b0;
            end
            if (issue_mark) begin
                busy[issue_rd] <= 1'b1;
            end
            num_pending <= num_pending + {{AW{1'b0}}, pend_inc} - {{AW{1'b0}}, pend_dec};
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard plus hand-written
// sequences for filling the scoreboard and reset during traffic.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        rs1_busy, rs2_busy, issue_valid, issue_uses_rs1, issue_uses_rs2;
    logic        stall, issue_accept, wb_valid;
    logic [5:0]  num_pending;

    int n_applied = 0;
    int n_errors  = 0;

    always #5 clock = ~clock;

    regfile_scoreboard dut (
        .clock          (clock),
        .reset          (reset),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_uses_rs1 (issue_uses_rs1),
        .issue_uses_rs2 (issue_uses_rs2),
        .stall          (stall),
        .issue_accept   (issue_accept),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .num_pending    (num_pending)
    );

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        iv;
        logic [4:0]  ird;
        logic        u1;
        logic        u2;
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic        e_b1;
        logic        e_b2;
        logic        e_stall;
        logic        e_acc;
        logic [5:0]  e_np;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic iv,
                         input logic [4:0] ird, input logic u1, input logic u2,
                         input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
        rs1_addr       = r1;
        rs2_addr       = r2;
        issue_valid    = iv;
        issue_rd       = ird;
        issue_uses_rs1 = u1;
        issue_uses_rs2 = u2;
        wb_valid       = wv;
        wb_rd          = wrd;
        wb_data        = wd;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        // rs1 rs2 iv ird u1 u2 wv wrd wd | d1 d2 b1 b2 stall acc np
        vecs[0]  = '{5'd5,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{5'd3,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[2]  = '{5'd3,  5'd3,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[3]  = '{5'd7,  5'd0,  1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 6'd0};
        vecs[4]  = '{5'd7,  5'd0,  1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 6'd1};
        vecs[5]  = '{5'd7,  5'd0,  1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 5'd7,  32'h42,       32'h42,       32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 6'd1};
        vecs[6]  = '{5'd7,  5'd10, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h42,       32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 6'd1};
        vecs[7]  = '{5'd9,  5'd0,  1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 6'd1};
        vecs[8]  = '{5'd9,  5'd0,  1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 6'd2};
        vecs[9]  = '{5'd9,  5'd0,  1'b1, 5'd9,  1'b0, 1'b0, 1'b1, 5'd9,  32'h99,       32'h99,       32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 6'd2};
        vecs[10] = '{5'd9,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h99,       32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 6'd2};
        vecs[11] = '{5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 6'd2};
        vecs[12] = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 6'd2};
        vecs[13] = '{5'd3,  5'd10, 1'b1, 5'd11, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 6'd2};
        vecs[14] = '{5'd4,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd4,  32'h1234,     32'h1234,     32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 6'd2};
        vecs[15] = '{5'd4,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h1234,     32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 6'd2};
        vecs[16] = '{5'd12, 5'd0,  1'b1, 5'd12, 1'b0, 1'b0, 1'b1, 5'd12, 32'h55,       32'h55,       32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 6'd2};
        vecs[17] = '{5'd12, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h55,       32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 6'd3};
        vecs[18] = '{5'd0,  5'd10, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd10, 32'hA,        32'h0,        32'hA,        1'b0, 1'b0, 1'b0, 1'b0, 6'd3};
        vecs[19] = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd9,  32'h9,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 6'd2};
        vecs[20] = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd12, 32'hC,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[21] = '{5'd9,  5'd12, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h9,        32'hC,        1'b0, 1'b0, 1'b0, 1'b0, 6'd0};

        reset = 1'b1;
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Inputs change on the falling edge and outputs are sampled 1 ns later.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].iv, vecs[i].ird, vecs[i].u1, vecs[i].u2,
                  vecs[i].wv, vecs[i].wrd, vecs[i].wd);
            #1;
            check($sformatf("v%0d rs1_data", i), rs1_data, vecs[i].e_d1);
            check($sformatf("v%0d rs2_data", i), rs2_data, vecs[i].e_d2);
            check($sformatf("v%0d rs1_busy", i), {31'h0, rs1_busy}, {31'h0, vecs[i].e_b1});
            check($sformatf("v%0d rs2_busy", i), {31'h0, rs2_busy}, {31'h0, vecs[i].e_b2});
            check($sformatf("v%0d stall", i), {31'h0, stall}, {31'h0, vecs[i].e_stall});
            check($sformatf("v%0d issue_accept", i), {31'h0, issue_accept}, {31'h0, vecs[i].e_acc});
            check($sformatf("v%0d num_pending", i), {26'h0, num_pending}, {26'h0, vecs[i].e_np});
            @(negedge clock);
        end

        // Fill the scoreboard: every register 1..31 becomes pending.
        for (int r = 1; r < 32; r++) begin
            drive(5'd0, 5'd0, 1'b1, 5'(r), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            #1;
            check($sformatf("fill r%0d issue_accept", r), {31'h0, issue_accept}, 32'h1);
            check($sformatf("fill r%0d num_pending", r), {26'h0, num_pending}, 32'(r - 1));
            @(negedge clock);
        end
        idle();
        #1;
        check("full num_pending", {26'h0, num_pending}, 32'd31);
        drive(5'd31, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        check("full waw stall", {31'h0, stall}, 32'h1);
        check("full rs1_busy", {31'h0, rs1_busy}, 32'h1);
        check("full rs2_busy", {31'h0, rs2_busy}, 32'h1);

        // Reset during traffic: writeback and issue of this cycle must leave no trace.
        @(negedge clock);
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h777);
        @(negedge clock);
        reset = 1'b0;
        idle();
        #1;
        check("post-reset num_pending", {26'h0, num_pending}, 32'd0);
        check("post-reset stall", {31'h0, stall}, 32'h0);
        for (int r = 1; r < 32; r++) begin
            rs1_addr = 5'(r);
            rs2_addr = 5'(32 - r);
            #1;
            check($sformatf("post-reset r%0d data", r), rs1_data, 32'h0);
            check($sformatf("post-reset r%0d busy", r), {31'h0, rs1_busy}, 32'h0);
            check($sformatf("post-reset r%0d busy2", 32 - r), {31'h0, rs2_busy}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_errors);
        $finish;
    end

endmodule
